// File: rtl/liteic_pkg.sv
// liteic_pkg: shared widths, slot count and write-arbiter state encoding for the liteic crossbar
package liteic_pkg;
  localparam int IC_NUM_MASTER_SLOTS = 4;
  localparam int IC_AWADDR_WIDTH     = 32;
  localparam int IC_WDATA_WIDTH      = 36;
  localparam int IC_BRESP_WIDTH      = 2;
  localparam int IC_QOS_WIDTH        = 4;
  localparam int IC_STARVE_LIMIT     = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_RESP} ic_wr_arb_state_t;
endpackage

// File: rtl/liteic_qos_rr_arbiter.sv
// liteic_qos_rr_arbiter: one-hot pick of the highest-QoS requester, ties broken round-robin after rr_ptr
module liteic_qos_rr_arbiter #(
  parameter int N  = 4,
  parameter int QW = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [QW-1:0]        eq_i [N],
  input  logic [$clog2(N)-1:0] rr_ptr_i,
  output logic [N-1:0]         gnt_o
);
  localparam int PW = $clog2(N);
  logic [QW-1:0] mx;
  logic [PW-1:0] idx;
  logic          found;
  // find the top QoS among requesters, then scan from rr_ptr+1 for the first requester holding it
  always_comb begin
    mx    = '0;
    idx   = '0;
    found = 1'b0;
    gnt_o = '0;
    for (int i = 0; i < N; i++)
      if (req_i[i] && eq_i[i] > mx) mx = eq_i[i];
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(rr_ptr_i) + k) % N);
      if (!found && req_i[idx] && eq_i[idx] == mx) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/liteic_slave_node_write_arb.sv
// liteic_slave_node_write_arb: per-slave-slot AW/W/B arbiter, QoS + round-robin with ageing, grant held to B
module liteic_slave_node_write_arb
  import liteic_pkg::*;
#(
  parameter int NUM_MASTERS  = IC_NUM_MASTER_SLOTS,
  parameter int AWADDR_WIDTH = IC_AWADDR_WIDTH,
  parameter int WDATA_WIDTH  = IC_WDATA_WIDTH,
  parameter int BRESP_WIDTH  = IC_BRESP_WIDTH,
  parameter int STARVE_LIMIT = IC_STARVE_LIMIT
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_MASTERS-1:0]  mst_aw_val_i,
  input  logic [AWADDR_WIDTH-1:0] mst_aw_addr_i [NUM_MASTERS],
  input  logic [3:0]              mst_aw_qos_i [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0]  mst_aw_rdy_o,
  input  logic [NUM_MASTERS-1:0]  mst_w_val_i,
  input  logic [WDATA_WIDTH-1:0]  mst_w_data_i [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0]  mst_w_rdy_o,
  output logic [NUM_MASTERS-1:0]  mst_b_val_o,
  output logic [BRESP_WIDTH-1:0]  mst_b_resp_o,
  input  logic [NUM_MASTERS-1:0]  mst_b_rdy_i,
  output logic                    slv_aw_val_o,
  output logic [AWADDR_WIDTH-1:0] slv_aw_addr_o,
  output logic [3:0]              slv_aw_qos_o,
  input  logic                    slv_aw_rdy_i,
  output logic                    slv_w_val_o,
  output logic [WDATA_WIDTH-1:0]  slv_w_data_o,
  input  logic                    slv_w_rdy_i,
  input  logic                    slv_b_val_i,
  input  logic [BRESP_WIDTH-1:0]  slv_b_resp_i,
  output logic                    slv_b_rdy_o,
  output logic [NUM_MASTERS-1:0]  grant_o,
  output logic                    busy_o
);
  localparam int PW = $clog2(NUM_MASTERS);
  localparam logic [IC_QOS_WIDTH-1:0] SL = IC_QOS_WIDTH'(STARVE_LIMIT);
  ic_wr_arb_state_t        state_q;
  logic [NUM_MASTERS-1:0]  grant_q, win;
  logic [PW-1:0]           rr_ptr_q, gidx;
  logic                    aw_done_q, w_done_q, xfer, resp, aw_hs, w_hs, b_hs;
  logic [IC_QOS_WIDTH-1:0] age_q [NUM_MASTERS];
  logic [IC_QOS_WIDTH-1:0] eq [NUM_MASTERS];
  assign xfer         = state_q == ARB_XFER;
  assign resp         = state_q == ARB_RESP;
  assign slv_aw_val_o = xfer & |(mst_aw_val_i & grant_q) & ~aw_done_q;
  assign slv_w_val_o  = xfer & |(mst_w_val_i & grant_q) & ~w_done_q;
  assign mst_aw_rdy_o = (xfer & slv_aw_rdy_i & ~aw_done_q) ? grant_q : '0;
  assign mst_w_rdy_o  = (xfer & slv_w_rdy_i & ~w_done_q) ? grant_q : '0;
  assign aw_hs        = slv_aw_val_o & slv_aw_rdy_i;
  assign w_hs         = slv_w_val_o & slv_w_rdy_i;
  assign slv_b_rdy_o  = resp & |(mst_b_rdy_i & grant_q);
  assign mst_b_val_o  = (resp & slv_b_val_i) ? grant_q : '0;
  assign mst_b_resp_o = resp ? slv_b_resp_i : '0;
  assign b_hs         = slv_b_val_i & slv_b_rdy_o;
  assign grant_o      = grant_q;
  assign busy_o       = state_q != ARB_IDLE;
  // starved masters compete at top QoS; the granted master's payload is steered to the slave
  always_comb begin
    gidx          = '0;
    slv_aw_addr_o = '0;
    slv_aw_qos_o  = '0;
    slv_w_data_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eq[i] = (age_q[i] == SL) ? 4'hF : mst_aw_qos_i[i];
      if (grant_q[i]) begin
        gidx          = PW'(i);
        slv_aw_addr_o = mst_aw_addr_i[i];
        slv_aw_qos_o  = mst_aw_qos_i[i];
        slv_w_data_o  = mst_w_data_i[i];
      end
    end
  end
  liteic_qos_rr_arbiter #(.N(NUM_MASTERS), .QW(IC_QOS_WIDTH)) u_arb (
    .req_i    (mst_aw_val_i),
    .eq_i     (eq),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (win)
  );
  // arbitration FSM: grant in IDLE, collect AW/W in XFER, release on the B handshake in RESP
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= PW'(NUM_MASTERS - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) age_q[i] <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          for (int i = 0; i < NUM_MASTERS; i++)
            if (!mst_aw_val_i[i] || win[i]) age_q[i] <= '0;
            else if (age_q[i] != SL) age_q[i] <= age_q[i] + 1'b1;
          if (|mst_aw_val_i) begin
            grant_q <= win;
            state_q <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          aw_done_q <= aw_done_q | aw_hs;
          w_done_q  <= w_done_q | w_hs;
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_q <= ARB_RESP;
        end
        ARB_RESP: if (b_hs) begin
          state_q   <= ARB_IDLE;
          rr_ptr_q  <= gidx;
          grant_q   <= '0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
  a_aw_hold: assert property (@(posedge clk_i) disable iff (!rstn_i) slv_aw_val_o && !slv_aw_rdy_i |=> slv_aw_val_o);
  a_w_hold: assert property (@(posedge clk_i) disable iff (!rstn_i) slv_w_val_o && !slv_w_rdy_i |=> slv_w_val_o);
endmodule

// File: tb/tb_liteic_slave_node_write_arb.sv
// tb_liteic_slave_node_write_arb: directed checks of grant order, handshakes, ageing and async reset
module tb_liteic_slave_node_write_arb;
  localparam int NM = 4;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  aw_val, w_val, b_rdy, aw_rdy, w_rdy, b_val, grant;
  logic [31:0] addr [NM];
  logic [3:0]  qos [NM];
  logic [35:0] data [NM];
  logic [1:0]  b_resp, slv_b_resp;
  logic        slv_aw_val, slv_aw_rdy, slv_w_val, slv_w_rdy, slv_b_val, slv_b_rdy, busy;
  logic [31:0] slv_aw_addr;
  logic [3:0]  slv_aw_qos;
  logic [35:0] slv_w_data;
  int vectors = 0;
  int errs = 0;
  always #5 clk_i = ~clk_i;
  liteic_slave_node_write_arb dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .mst_aw_val_i(aw_val), .mst_aw_addr_i(addr), .mst_aw_qos_i(qos), .mst_aw_rdy_o(aw_rdy),
    .mst_w_val_i(w_val), .mst_w_data_i(data), .mst_w_rdy_o(w_rdy),
    .mst_b_val_o(b_val), .mst_b_resp_o(b_resp), .mst_b_rdy_i(b_rdy),
    .slv_aw_val_o(slv_aw_val), .slv_aw_addr_o(slv_aw_addr), .slv_aw_qos_o(slv_aw_qos), .slv_aw_rdy_i(slv_aw_rdy),
    .slv_w_val_o(slv_w_val), .slv_w_data_o(slv_w_data), .slv_w_rdy_i(slv_w_rdy),
    .slv_b_val_i(slv_b_val), .slv_b_resp_i(slv_b_resp), .slv_b_rdy_o(slv_b_rdy),
    .grant_o(grant), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic req(input int m, input logic [3:0] q);
    aw_val[m] = 1'b1;
    w_val[m]  = 1'b1;
    qos[m]    = q;
  endtask
  task automatic do_reset;
    aw_val = '0;
    w_val  = '0;
    rstn_i = 1'b0;
    #2;
    rstn_i = 1'b1;
  endtask
  task automatic do_write(input int m, input bit drop, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << m;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_grant"}, grant, 0);
    tick;
    slv_aw_rdy = 1'b1;
    slv_w_rdy  = 1'b1;
    slv_b_val  = 1'b1;
    #1;
    chk({tag, "_xfer_grant"}, grant, oh);
    chk({tag, "_aw_addr"}, slv_aw_addr, addr[m]);
    chk({tag, "_aw_qos"}, slv_aw_qos, qos[m]);
    chk({tag, "_w_data"}, slv_w_data, data[m]);
    chk({tag, "_aw_rdy"}, aw_rdy, oh);
    chk({tag, "_w_rdy"}, w_rdy, oh);
    chk({tag, "_b_held"}, slv_b_rdy, 0);
    tick;
    slv_aw_rdy = 1'b0;
    slv_w_rdy  = 1'b0;
    if (drop) begin
      aw_val[m] = 1'b0;
      w_val[m]  = 1'b0;
    end
    #1;
    chk({tag, "_resp_grant"}, grant, oh);
    chk({tag, "_b_val"}, b_val, oh);
    chk({tag, "_b_rdy"}, slv_b_rdy, 1);
    tick;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    rstn_i     = 1'b0;
    aw_val     = '0;
    w_val      = '0;
    b_rdy      = 4'hF;
    slv_aw_rdy = 1'b0;
    slv_w_rdy  = 1'b0;
    slv_b_val  = 1'b1;
    slv_b_resp = 2'b00;
    for (int i = 0; i < NM; i++) begin
      addr[i] = 32'(i + 1) << 12;
      data[i] = 36'hA00 + 36'(i);
      qos[i]  = 4'h0;
    end
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_rdy", slv_b_rdy, 0);
    chk("rst_aw_val", slv_aw_val, 0);
    chk("rst_aw_rdy", aw_rdy, 0);
    #1;
    rstn_i = 1'b1;
    addr[2] = 32'h100;
    req(2, 4'h0);
    do_write(2, 1, "t1");
    chk("t1_after_busy", busy, 0);
    chk("t1_after_bval", b_val, 0);
    chk("t1_b_resp", b_resp, 0);
    do_reset;
    req(0, 4'd1); req(1, 4'd7); req(2, 4'd7); req(3, 4'd3);
    do_write(1, 1, "t2a");
    do_write(2, 1, "t2b");
    do_write(3, 1, "t2c");
    do_write(0, 1, "t2d");
    do_reset;
    for (int i = 0; i < NM; i++) req(i, 4'd5);
    do_write(0, 0, "t3a");
    do_write(1, 0, "t3b");
    do_write(2, 0, "t3c");
    do_write(3, 0, "t3d");
    do_write(0, 0, "t3e");
    do_reset;
    req(1, 4'd0);
    chk("t4_idle", busy, 0);
    tick;
    slv_aw_rdy = 1'b0;
    slv_w_rdy  = 1'b0;
    #1;
    chk("t4_c1_grant", grant, 4'b0010);
    chk("t4_c1_wval", slv_w_val, 1);
    chk("t4_c1_wrdy", w_rdy, 0);
    chk("t4_c1_awrdy", aw_rdy, 0);
    tick;
    slv_w_rdy = 1'b1;
    #1;
    chk("t4_c2_wrdy", w_rdy, 4'b0010);
    tick;
    #1;
    chk("t4_c3_wrdy", w_rdy, 0);
    chk("t4_c3_wval", slv_w_val, 0);
    chk("t4_c3_awval", slv_aw_val, 1);
    chk("t4_c3_brdy", slv_b_rdy, 0);
    chk("t4_c3_busy", busy, 1);
    tick;
    slv_aw_rdy = 1'b1;
    #1;
    chk("t4_c4_awrdy", aw_rdy, 4'b0010);
    chk("t4_c4_brdy", slv_b_rdy, 0);
    tick;
    slv_aw_rdy = 1'b0;
    slv_w_rdy  = 1'b0;
    aw_val[1]  = 1'b0;
    w_val[1]   = 1'b0;
    #1;
    chk("t4_resp_brdy", slv_b_rdy, 1);
    chk("t4_resp_bval", b_val, 4'b0010);
    tick;
    chk("t4_done", busy, 0);
    do_reset;
    req(0, 4'd15);
    req(3, 4'd0);
    for (int k = 0; k < 8; k++) do_write(0, 0, "t5_m0");
    do_write(3, 1, "t5_m3");
    aw_val = '0;
    w_val  = '0;
    do_reset;
    req(1, 4'd2);
    b_rdy      = 4'h0;
    slv_b_resp = 2'b10;
    tick;
    slv_aw_rdy = 1'b1;
    slv_w_rdy  = 1'b1;
    slv_b_val  = 1'b1;
    tick;
    slv_aw_rdy = 1'b0;
    slv_w_rdy  = 1'b0;
    #1;
    chk("t6_resp_bval", b_val, 4'b0010);
    chk("t6_resp_bresp", b_resp, 2'b10);
    chk("t6_resp_brdy", slv_b_rdy, 0);
    chk("t6_resp_busy", busy, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_bval", b_val, 0);
    chk("t6_rst_bresp", b_resp, 0);
    #1;
    rstn_i = 1'b1;
    b_rdy  = 4'hF;
    tick;
    chk("t6_rearb_grant", grant, 4'b0010);
    chk("t6_rearb_awval", slv_aw_val, 1);
    slv_aw_rdy = 1'b1;
    slv_w_rdy  = 1'b1;
    tick;
    slv_aw_rdy = 1'b0;
    slv_w_rdy  = 1'b0;
    aw_val[1]  = 1'b0;
    w_val[1]   = 1'b0;
    #1;
    chk("t6_b_val", b_val, 4'b0010);
    tick;
    chk("t6_done", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
